// File: rtl/id_ex_stage.sv
// id_ex_stage: ID/EX pipeline register with ALU-control decode and EX operand forwarding.
module id_ex_stage #(
  parameter int N = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         stall,
  input  logic         flush,
  input  logic         id_valid,
  input  logic [N-1:0] id_rs1_data,
  input  logic [N-1:0] id_rs2_data,
  input  logic [N-1:0] id_imm,
  input  logic [4:0]   id_rs1,
  input  logic [4:0]   id_rs2,
  input  logic [4:0]   id_rd,
  input  logic [1:0]   id_aluop,
  input  logic [2:0]   id_funct3,
  input  logic         id_funct7b5,
  input  logic         id_alusrc,
  input  logic         id_regwrite,
  input  logic         exm_regwrite,
  input  logic [4:0]   exm_rd,
  input  logic [N-1:0] exm_result,
  input  logic         mwb_regwrite,
  input  logic [4:0]   mwb_rd,
  input  logic [N-1:0] mwb_result,
  output logic [N-1:0] ex_a,
  output logic [N-1:0] ex_b,
  output logic [3:0]   ex_aluop,
  output logic         ex_valid,
  output logic         ex_regwrite,
  output logic         ex_illegal,
  output logic [4:0]   ex_rd,
  output logic [N-1:0] ex_store_data
);
  logic         valid_q, regwrite_q, illegal_q, alusrc_q;
  logic [4:0]   rs1_q, rs2_q, rd_q;
  logic [N-1:0] rs1_data_q, rs2_data_q, imm_q;
  logic [3:0]   code_q, code_d;
  logic [N-1:0] fwd_a, fwd_b;
  // funct3 110/111 mean or/and for both R and I classes; 000 is add except R-type with funct7b5
  always_comb begin
    code_d = id_aluop == 2'b00 ? 4'b0010 :
             id_aluop == 2'b01 ? 4'b0110 :
             id_funct3 == 3'b110 ? 4'b0001 :
             id_funct3 == 3'b111 ? 4'b0000 :
             id_funct3 == 3'b000 ? ((id_aluop[0] | ~id_funct7b5) ? 4'b0010 : 4'b0110) :
             4'b1111;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q    <= 1'b0;
      regwrite_q <= 1'b0;
      illegal_q  <= 1'b0;
      alusrc_q   <= 1'b0;
      rs1_q      <= '0;
      rs2_q      <= '0;
      rd_q       <= '0;
      rs1_data_q <= '0;
      rs2_data_q <= '0;
      imm_q      <= '0;
      code_q     <= '0;
    end else begin
      if (flush) begin
        valid_q    <= 1'b0;
        regwrite_q <= 1'b0;
        illegal_q  <= 1'b0;
      end else if (!stall) begin
        valid_q    <= id_valid;
        regwrite_q <= id_regwrite;
        illegal_q  <= id_valid && code_d == 4'b1111;
      end
      if (!stall) begin
        alusrc_q   <= id_alusrc;
        rs1_q      <= id_rs1;
        rs2_q      <= id_rs2;
        rd_q       <= id_rd;
        rs1_data_q <= id_rs1_data;
        rs2_data_q <= id_rs2_data;
        imm_q      <= id_imm;
        code_q     <= code_d;
      end
    end
  end
  // EX/MEM is the younger producer, so it wins over MEM/WB; x0 is never forwarded
  assign fwd_a = (exm_regwrite && exm_rd == rs1_q && rs1_q != 5'd0) ? exm_result :
                 (mwb_regwrite && mwb_rd == rs1_q && rs1_q != 5'd0) ? mwb_result : rs1_data_q;
  assign fwd_b = (exm_regwrite && exm_rd == rs2_q && rs2_q != 5'd0) ? exm_result :
                 (mwb_regwrite && mwb_rd == rs2_q && rs2_q != 5'd0) ? mwb_result : rs2_data_q;
  assign ex_a          = fwd_a;
  assign ex_b          = alusrc_q ? imm_q : fwd_b;
  assign ex_store_data = fwd_b;
  assign ex_aluop      = code_q;
  assign ex_valid      = valid_q;
  assign ex_regwrite   = regwrite_q & valid_q;
  assign ex_illegal    = illegal_q & valid_q;
  assign ex_rd         = rd_q;
endmodule
